// File: rtl/queue_ctrl_if.sv
// ============================================================================
// Module      : queue_ctrl_if
// Description : Requester, pop and RegFile signals of the circular-buffer
//               queue sequencer. drop_cnt exists only with QUEUE_CTRL_STAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface queue_ctrl_if #(
  parameter int QL = 3,
  parameter int QW = 4
);
  logic [1:0]    push_req;
  logic [QW-1:0] push_data0;
  logic [QW-1:0] push_data1;
  logic [1:0]    push_gnt;
  logic          pop_req;
  logic          pop_valid;
  logic [QW-1:0] pop_data;
  logic          flush;
  logic          rf_we;
  logic [QL-1:0] rf_wa;
  logic [QW-1:0] rf_wd;
  logic [QL-1:0] rf_ra;
  logic [QW-1:0] rf_rd;
  logic [QL-1:0] head;
  logic [QL-1:0] tail;
  logic [QL:0]   count;
  logic          empty;
  logic          full;
`ifdef QUEUE_CTRL_STAT_EN
  logic [7:0]    drop_cnt;
`endif

  modport slave (
    input  push_req, push_data0, push_data1, pop_req, flush, rf_rd,
    output push_gnt, pop_valid, pop_data, rf_we, rf_wa, rf_wd, rf_ra,
           head, tail, count, empty, full
`ifdef QUEUE_CTRL_STAT_EN
    , output drop_cnt
`endif
  );

  modport master (
    output push_req, push_data0, push_data1, pop_req, flush, rf_rd,
    input  push_gnt, pop_valid, pop_data, rf_we, rf_wa, rf_wd, rf_ra,
           head, tail, count, empty, full
`ifdef QUEUE_CTRL_STAT_EN
    , input drop_cnt
`endif
  );
endinterface

`default_nettype wire

// File: rtl/queue_ctrl.sv
// ============================================================================
// Module      : queue_ctrl
// Description : Round-robin two-requester push / single pop sequencer for a
//               RegFile-backed circular queue. Optional drop counter when
//               QUEUE_CTRL_STAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module queue_ctrl #(
  parameter int QL = 3,
  parameter int QW = 4
) (
  input  wire logic   clk100,
  input  wire logic   rst_n,
  queue_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [QL:0] c_PTR_ONE = (QL+1)'(1);

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [QL:0]   r_head;
  logic [QL:0]   r_tail;
  logic          r_rr_last;
  logic          r_pop_valid;
  logic [QW-1:0] r_pop_data;
  logic [1:0]    w_gnt;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic          w_flush_entry;

  // Wrap bit distinguishes full from empty when the slot indices coincide.
  assign w_empty       = (r_head == r_tail);
  assign w_full        = (r_head[QL-1:0] == r_tail[QL-1:0]) && (r_head[QL] != r_tail[QL]);
  assign w_flush_entry = (r_state == S_RUN) && bus.flush;

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = S_RUN;
      S_RUN:   w_next_state = bus.flush ? S_FLUSH : S_RUN;
      S_FLUSH: w_next_state = S_RUN;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_gnt = 2'b00;
    w_pop = 1'b0;
    if ((r_state == S_RUN) && !bus.flush) begin
      if (!w_full) begin
        case (bus.push_req)
          2'b01:   w_gnt = 2'b01;
          2'b10:   w_gnt = 2'b10;
          2'b11:   w_gnt = r_rr_last ? 2'b01 : 2'b10;
          default: w_gnt = 2'b00;
        endcase
      end
      w_pop = bus.pop_req && !w_empty;
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_rr_last   <= 1'b1;
      r_pop_valid <= 1'b0;
      r_pop_data  <= '0;
    end else begin
      r_pop_valid <= w_pop;
      if (w_pop) r_pop_data <= bus.rf_rd;
      if (w_flush_entry) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (|w_gnt) begin
          r_head    <= r_head + c_PTR_ONE;
          r_rr_last <= w_gnt[1];
        end
        if (w_pop) r_tail <= r_tail + c_PTR_ONE;
      end
    end
  end

  assign bus.push_gnt  = w_gnt;
  assign bus.rf_we     = |w_gnt;
  assign bus.rf_wa     = r_head[QL-1:0];
  assign bus.rf_wd     = w_gnt[1] ? bus.push_data1 : (w_gnt[0] ? bus.push_data0 : '0);
  assign bus.rf_ra     = r_tail[QL-1:0];
  assign bus.head      = r_head[QL-1:0];
  assign bus.tail      = r_tail[QL-1:0];
  assign bus.count     = r_head - r_tail;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.pop_valid = r_pop_valid;
  assign bus.pop_data  = r_pop_data;

`ifdef QUEUE_CTRL_STAT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_flush_entry) begin
      r_drop_cnt <= '0;
    end else if ((r_state == S_RUN) && w_full && (bus.push_req != 2'b00)
                 && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign bus.drop_cnt = r_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_queue_ctrl.sv
// ============================================================================
// Module      : tb_queue_ctrl
// Description : Scoreboard bench for queue_ctrl with a behavioural RegFile.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_queue_ctrl;
  localparam int QL    = 3;
  localparam int QW    = 4;
  localparam int DEPTH = 2**QL;

  logic clk100 = 1'b0;
  logic rst_n;
  always #5 clk100 = ~clk100;

  queue_ctrl_if #(.QL(QL), .QW(QW)) qif ();
  queue_ctrl #(.QL(QL), .QW(QW)) dut (.clk100(clk100), .rst_n(rst_n), .bus(qif.slave));

  logic [QW-1:0] mem [0:DEPTH-1];
  always @(posedge clk100) if (qif.rf_we) mem[qif.rf_wa] <= qif.rf_wd;
  assign qif.rf_rd = mem[qif.rf_ra];

  int errors = 0;
  int checks = 0;

  // Reference model: sb holds queue contents in order
  logic [QW-1:0] sb[$];
  int            m_state;
  logic [QL:0]   m_head, m_tail;
  logic          m_rr;
  logic [QW-1:0] m_pop_data;
  int            m_drop;

  task automatic model_reset();
    sb.delete();
    m_state = 0; m_head = '0; m_tail = '0; m_rr = 1'b1;
    m_pop_data = '0; m_drop = 0;
  endtask

  // Assert reset at the current time and check asynchronous outputs.
  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    qif.push_req = 2'b00; qif.push_data0 = '0; qif.push_data1 = '0;
    qif.pop_req = 1'b0; qif.flush = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({qif.push_gnt, qif.rf_we, qif.rf_wd, qif.count, qif.empty, qif.full,
         qif.pop_valid, qif.pop_data, qif.head, qif.tail, qif.rf_wa, qif.rf_ra}
        !== {2'b00, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL %s reset_outputs: gnt=%b we=%b wd=%0d count=%0d empty=%b full=%b pv=%b pd=%0d head=%0d tail=%0d, required all 0 with empty=1",
               tag, qif.push_gnt, qif.rf_we, qif.rf_wd, qif.count, qif.empty, qif.full,
               qif.pop_valid, qif.pop_data, qif.head, qif.tail);
    end
`ifdef QUEUE_CTRL_STAT_EN
    checks++;
    if (qif.drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL %s reset_drop_cnt: got %0d required 0", tag, qif.drop_cnt);
    end
`endif
    @(negedge clk100);
    @(negedge clk100);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, update the
  // model at the edge, then check registered pop outputs at the next negedge.
  task automatic cycle(input logic [1:0] req, input logic [QW-1:0] d0, input logic [QW-1:0] d1,
                       input logic pop, input logic fl);
    logic [1:0]    eg;
    logic          ep, mf, me;
    logic [QW-1:0] ewd;
    qif.push_req = req; qif.push_data0 = d0; qif.push_data1 = d1;
    qif.pop_req = pop; qif.flush = fl;
    #1;
    mf = (sb.size() == DEPTH);
    me = (sb.size() == 0);
    eg = 2'b00;
    if (m_state == 1 && !fl && !mf) begin
      if (req == 2'b01)      eg = 2'b01;
      else if (req == 2'b10) eg = 2'b10;
      else if (req == 2'b11) eg = m_rr ? 2'b01 : 2'b10;
    end
    ep  = (m_state == 1) && !fl && pop && !me;
    ewd = eg[1] ? d1 : (eg[0] ? d0 : '0);

    checks++;
    if ({qif.push_gnt, qif.rf_we, qif.rf_wd} !== {eg, |eg, ewd}) begin
      errors++;
      $display("FAIL grant: gnt=%b we=%b wd=%0d required gnt=%b we=%b wd=%0d",
               qif.push_gnt, qif.rf_we, qif.rf_wd, eg, |eg, ewd);
    end
    checks++;
    if ({qif.count, qif.empty, qif.full} !== {(QL+1)'(sb.size()), me, mf}) begin
      errors++;
      $display("FAIL status: count=%0d empty=%b full=%b required count=%0d empty=%b full=%b",
               qif.count, qif.empty, qif.full, sb.size(), me, mf);
    end
    checks++;
    if ({qif.head, qif.tail, qif.rf_wa, qif.rf_ra}
        !== {m_head[QL-1:0], m_tail[QL-1:0], m_head[QL-1:0], m_tail[QL-1:0]}) begin
      errors++;
      $display("FAIL pointers: head=%0d tail=%0d wa=%0d ra=%0d required head=%0d tail=%0d",
               qif.head, qif.tail, qif.rf_wa, qif.rf_ra, m_head[QL-1:0], m_tail[QL-1:0]);
    end
`ifdef QUEUE_CTRL_STAT_EN
    checks++;
    if (qif.drop_cnt !== 8'(m_drop)) begin
      errors++;
      $display("FAIL drop_cnt: got %0d required %0d", qif.drop_cnt, m_drop);
    end
`endif

    @(posedge clk100);
    if (ep) begin
      m_pop_data = sb.pop_front();
      m_tail = m_tail + 1'b1;
    end
    if (|eg) begin
      sb.push_back(ewd);
      m_head = m_head + 1'b1;
      m_rr = eg[1];
    end
    if (m_state == 1) begin
      if (fl) m_drop = 0;
      else if (mf && req != 2'b00 && m_drop < 255) m_drop++;
    end
    if (m_state == 0 || m_state == 2) begin
      m_state = 1;
    end else if (fl) begin
      m_state = 2;
      sb.delete();
      m_head = '0; m_tail = '0;
    end

    @(negedge clk100);
    checks++;
    if ({qif.pop_valid, qif.pop_data} !== {ep, m_pop_data}) begin
      errors++;
      $display("FAIL pop: valid=%b data=%0d required valid=%b data=%0d",
               qif.pop_valid, qif.pop_data, ep, m_pop_data);
    end
  endtask

  task automatic test_reset();
    apply_reset("initial");
    cycle(2'b11, 4'd1, 4'd2, 1'b1, 1'b0);  // S_IDLE: no grant, no pop
  endtask

  task automatic test_arbitration();
    for (int i = 0; i < DEPTH; i++) cycle(2'b11, 4'd3, 4'd5, 1'b0, 1'b0);
    cycle(2'b11, 4'd3, 4'd5, 1'b0, 1'b0);  // full: no grant
    for (int i = 0; i < DEPTH; i++) begin
      logic [QW-1:0] exp_slot;
      exp_slot = (i % 2 == 0) ? 4'd3 : 4'd5;
      checks++;
      if (mem[i] !== exp_slot) begin
        errors++;
        $display("FAIL regfile_slot%0d: got %0d required %0d", i, mem[i], exp_slot);
      end
    end
  endtask

  task automatic test_pop_drain();
    for (int i = 0; i < DEPTH; i++) cycle(2'b00, 4'd0, 4'd0, 1'b1, 1'b0);
    cycle(2'b00, 4'd0, 4'd0, 1'b1, 1'b0);  // pop while empty ignored
    cycle(2'b00, 4'd0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) cycle(2'b01, 4'(i + 1), 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(2'b01, 4'(i + 7), 4'd15, 1'b1, 1'b0);
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) cycle(2'b10, 4'd0, 4'(i + 9), 1'b0, 1'b0);
    cycle(2'b10, 4'd0, 4'd13, 1'b1, 1'b0);  // full: pop only
    cycle(2'b10, 4'd0, 4'd14, 1'b0, 1'b0);  // now granted
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) cycle(2'b00, 4'd0, 4'd0, 1'b1, 1'b0);
    cycle(2'b11, 4'd1, 4'd2, 1'b1, 1'b1);
    cycle(2'b11, 4'd1, 4'd2, 1'b1, 1'b0);   // S_FLUSH: nothing happens
    cycle(2'b01, 4'd6, 4'd0, 1'b0, 1'b1);   // held flush
    cycle(2'b01, 4'd6, 4'd0, 1'b0, 1'b1);
    cycle(2'b01, 4'd6, 4'd0, 1'b0, 1'b1);
    cycle(2'b11, 4'd8, 4'd9, 1'b0, 1'b0);
    cycle(2'b11, 4'd10, 4'd11, 1'b1, 1'b0);
    cycle(2'b00, 4'd0, 4'd0, 1'b1, 1'b0);
    cycle(2'b00, 4'd0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cycle(2'b10, 4'd0, 4'(i + 2), 1'b0, 1'b0);
    #2;
    apply_reset("mid");
    cycle(2'b01, 4'd4, 4'd0, 1'b1, 1'b0);
    cycle(2'b01, 4'd4, 4'd0, 1'b1, 1'b0);
    cycle(2'b00, 4'd0, 4'd0, 1'b1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rst_n = 1'b0;
    @(negedge clk100);
    test_reset();
    test_arbitration();
    test_pop_drain();
    test_wrap();
    test_full_pop();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/queue_ctrl.md
Name: queue_ctrl

Overview:
- Sequencer and arbiter for the shared circular-buffer queue built on the RegFile block.
- Owns the head/tail pointers and drives the RegFile write port (we/wa/wd) and one read port (ra/rd).
- Arbitrates between two push requesters with round-robin priority and serves one pop requester.
- Sits between the board-level input logic (switch/button front end) and the RegFile; empty/full/count go to LEDs and the display scanner.

Parameters:
- QL, 3, pointer width; queue depth = 2**QL entries (all slots usable).
- QW, 4, data word width.

Ports:
- clk100  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- push_req  in  2  push request; bit i from requester i; level, held until granted.
- push_data0  in  QW  data from requester 0.
- push_data1  in  QW  data from requester 1.
- push_gnt  out  2  one-hot grant, combinational, same cycle as the write.
- pop_req  in  1  pop request, level.
- pop_valid  out  1  one-cycle pulse; pop_data valid.
- pop_data  out  QW  registered dequeued word.
- flush  in  1  synchronous queue clear request.
- rf_we  out  1  RegFile write enable.
- rf_wa  out  QL  RegFile write address (= head).
- rf_wd  out  QW  RegFile write data (granted requester's data).
- rf_ra  out  QL  RegFile read address (= tail, always driven).
- rf_rd  in  QW  RegFile read data (combinational from rf_ra).
- head  out  QL  next write slot.
- tail  out  QL  next read slot.
- count  out  QL+1  occupancy, 0..2**QL.
- empty  out  1  count==0.
- full  out  1  count==2**QL.

Behaviour:
- Internal pointers are QL+1 bits wide; the MSB is a wrap bit.
  - empty when the pointers are equal.
  - full when the low QL bits are equal and the MSBs differ.
  - count = head_ext - tail_ext, modulo 2**(QL+1).
- FSM states:
  - S_IDLE: after reset; moves to S_RUN on the next edge; no grants.
  - S_RUN: normal operation.
  - S_FLUSH: entered from S_RUN when flush=1; lasts exactly one cycle; pointers are cleared to 0 at the entry edge; no grants, no pop; returns to S_RUN. A flush held high re-enters S_FLUSH repeatedly.
- Async reset (rst_n=0):
  - State S_IDLE; pointers 0; rr_last=1 (requester 0 has priority first); pop_data=0; pop_valid=0.
  - All combinational outputs are therefore 0 except empty=1, and rf_ra=0.
- Push arbitration (S_RUN, flush=0, full=0):
  - With a single requester, that requester is granted.
  - With both requesting, the one not granted last (rr_last) is granted.
  - At most one grant per cycle.
  - On the grant: rf_we=1, rf_wa=head[QL-1:0], rf_wd=the winner's data; head increments at the edge; rr_last updates to the winner.
  - When full=1, no grant is issued even if a pop happens in the same cycle, and rr_last is unchanged.
- Pop (S_RUN, flush=0, pop_req=1, empty=0):
  - The edge captures rf_rd (tail entry) into pop_data and pulses pop_valid=1 for the following cycle.
  - tail increments at the same edge. Latency is one cycle.
  - pop_req held high pops one entry per cycle until empty.
  - Pop while empty is ignored: pop_valid=0 and pop_data holds.
- Simultaneous push and pop on a non-empty, non-full queue: both happen; count unchanged.
- Push into an empty queue plus a pop in the same cycle: the pop is ignored, because empty is evaluated before the edge.
- Wrap-around: the low QL bits roll over from 2**QL-1 to 0 and the wrap bit toggles.
- Reset mid-operation discards all contents; stale RegFile data is not cleared by this block.

Optional Feature:
- Macro QUEUE_CTRL_STAT_EN.
- When defined:
  - Adds an output port drop_cnt, 8 bits.
  - Increments once per cycle in S_RUN while full=1 and push_req!=0.
  - Saturates at 255.
  - Cleared by reset and by flush.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
1. Reset, then release rst_n -> empty=1, count=0, push_gnt=00 in the first cycle (S_IDLE); a grant is possible from the second cycle on.
2. push_req=11 held with data0=3, data1=5, QL=3 -> grants alternate 01,10,01,...; RegFile slots 0..7 = 3,5,3,5,3,5,3,5; full=1 and count=8 after 8 cycles; no further grants.
3. From full, pop_req=1 for 8 cycles -> pop_data sequence 3,5,3,5,3,5,3,5, each one cycle after its request; then empty=1 and pop_valid stays 0.
4. Hold count=4 with push_req=01 and pop_req=1 for 10 cycles -> count stays 4; head and tail both wrap past 7→0; popped data in push order.
5. Hold full with push_req=10 and pop_req=1 for one cycle -> no grant, one pop, count=7; the grant is issued in the next cycle.
6. Assert flush at count=5 -> next cycle count=0, empty=1, no pop_valid; with QUEUE_CTRL_STAT_EN, drop_cnt=0 after flush.
